// File: rtl/buf_audio_pkg.sv
// ============================================================================
// Module  : buf_audio_pkg
// Brief   : Shared constants and FSM state type for the buf_audio blocks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package buf_audio_pkg;

  localparam int STEREO_MULTIPLIER   = 2;
  localparam int AUDIO_WIDTH_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } rd_sched_state_t;

endpackage

`default_nettype wire

// File: rtl/buf_audio_rd_sched_rr_arbiter.sv
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin arbiter; lowest requester at or after
//           ptr wins, wrapping modulo N. Output is one-hot (or zero).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = PW'((int'(ptr) + i) % N);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/buf_audio_rd_sched.sv
// ============================================================================
// Module  : buf_audio_rd_sched
// Brief   : Round-robin read scheduler between buf_audio_in and NUM_REQ
//           consumers; drains the buffer when full and idle.
//           Optional macro BUF_RD_SCHED_STATS_EN adds underrun/drop counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module buf_audio_rd_sched
  import buf_audio_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int NUM_AUDIO_CHANNELS = 2,
  parameter int AUDIO_WIDTH        = AUDIO_WIDTH_DEFAULT,
  parameter int RD_LATENCY         = 1
) (
  input  logic                                                     sys_clk,
  input  logic                                                     sys_rst_n,
  input  logic [NUM_REQ-1:0]                                       req,
  output logic [NUM_REQ-1:0]                                       gnt,
  output logic [NUM_AUDIO_CHANNELS*STEREO_MULTIPLIER*AUDIO_WIDTH-1:0] frame_data,
  output logic                                                     frame_valid,
  input  logic                                                     buffer_ready,
  input  logic                                                     buffer_full,
  input  logic [NUM_AUDIO_CHANNELS*STEREO_MULTIPLIER*AUDIO_WIDTH-1:0] audio_channel_in,
  output logic                                                     adv_read_enable,
`ifdef BUF_RD_SCHED_STATS_EN
  output logic [15:0]                                              underrun_cnt,
  output logic [15:0]                                              drop_cnt,
`endif
  output logic                                                     drop_pulse
);

  localparam int          c_mono     = NUM_AUDIO_CHANNELS * STEREO_MULTIPLIER;
  localparam int          c_fw       = c_mono * AUDIO_WIDTH;
  localparam int          c_pw       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0]  c_cnt_load = 3'(RD_LATENCY - 1);

  rd_sched_state_t     r_state, w_state_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_arb_gnt;
  logic                r_drain;
  logic [2:0]          r_cnt;
  logic [c_pw-1:0]     r_ptr, w_gnt_idx, w_ptr_nxt;
  logic [c_fw-1:0]     r_frame;
  logic                w_any_req, w_start_req, w_start_drain;

  assign w_any_req     = |req;
  assign w_start_req   = w_any_req && buffer_ready;
  assign w_start_drain = buffer_full && !w_any_req;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req),
    .ptr (r_ptr),
    .gnt (w_arb_gnt)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_gnt[i]) w_gnt_idx = c_pw'(i);
    end
    w_ptr_nxt = (w_gnt_idx == c_pw'(NUM_REQ - 1)) ? '0 : w_gnt_idx + c_pw'(1);
  end

  always_comb begin
    w_state_nxt     = r_state;
    adv_read_enable = 1'b0;
    frame_valid     = 1'b0;
    drop_pulse      = 1'b0;
    case (r_state)
      IDLE:    if (w_start_req || w_start_drain) w_state_nxt = ISSUE;
      ISSUE: begin
        adv_read_enable = 1'b1;
        w_state_nxt     = WAIT;
      end
      WAIT:    if (r_cnt == 3'd0) w_state_nxt = DELIVER;
      DELIVER: begin
        frame_valid = !r_drain;
        drop_pulse  = r_drain;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_drain <= 1'b0;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_frame <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        // A pending request always wins over a drain of a full buffer.
        IDLE: begin
          if (w_start_req) begin
            r_gnt   <= w_arb_gnt;
            r_drain <= 1'b0;
          end else if (w_start_drain) begin
            r_gnt   <= '0;
            r_drain <= 1'b1;
          end
        end
        ISSUE:   r_cnt <= c_cnt_load;
        WAIT: begin
          if (r_cnt == 3'd0) r_frame <= audio_channel_in;
          else               r_cnt   <= r_cnt - 3'd1;
        end
        DELIVER: begin
          r_gnt <= '0;
          if (!r_drain) r_ptr <= w_ptr_nxt;
        end
        default: ;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign frame_data = r_frame;

`ifdef BUF_RD_SCHED_STATS_EN
  logic [15:0] r_underrun_cnt, r_drop_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_underrun_cnt <= '0;
      r_drop_cnt     <= '0;
    end else begin
      if (r_state == IDLE && w_any_req && !buffer_ready && r_underrun_cnt != 16'hFFFF)
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
      if (drop_pulse && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
  assign drop_cnt     = r_drop_cnt;
`endif

endmodule

`default_nettype wire
